// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a word-access, byte-addressed data memory.
// One grant at a time: range check, a single memory strobe cycle, then a one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_LIMIT  = 256,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(ADDR_LIMIT - 4);

  state_t           r_state, w_state_next;
  logic             r_gnt, w_gnt_next;
  logic             r_last_grant, w_last_grant_next;
  logic             r_we, w_we_next;
  logic [1:0]       r_ack, w_ack_next;
  logic [1:0]       r_err, w_err_next;
  logic [1:0][31:0] r_rdata, w_rdata_next;
  logic [31:0]      r_mem_addr, w_mem_addr_next;
  logic [31:0]      r_mem_wdata, w_mem_wdata_next;
  logic             r_mem_read, w_mem_read_next;
  logic             r_mem_write, w_mem_write_next;

  logic [1:0]       w_req;
  logic [1:0]       w_we_in;
  logic [1:0][31:0] w_addr_in;
  logic [1:0][31:0] w_wdata_in;
  logic             w_pick;
  logic             w_legal;

  assign w_req      = {r1_req, r0_req};
  assign w_we_in    = {r1_we, r0_we};
  assign w_addr_in  = {r1_addr, r0_addr};
  assign w_wdata_in = {r1_wdata, r0_wdata};

  // On contention, round robin favours the port that did not win last time.
  always_comb begin
    if (w_req == 2'b11) w_pick = ROUND_ROBIN ? ~r_last_grant : 1'b0;
    else                w_pick = w_req[1];
  end

  assign w_legal = (w_addr_in[w_pick] <= LAST_ADDR);

  always_comb begin
    w_state_next      = r_state;
    w_gnt_next        = r_gnt;
    w_last_grant_next = r_last_grant;
    w_we_next         = r_we;
    w_ack_next        = '0;
    w_err_next        = '0;
    w_rdata_next      = r_rdata;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_mem_read_next   = 1'b0;
    w_mem_write_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_gnt_next        = w_pick;
          w_last_grant_next = w_pick;
          w_we_next         = w_we_in[w_pick];
          if (w_legal) begin
            w_state_next     = ACCESS;
            w_mem_addr_next  = w_addr_in[w_pick];
            w_mem_wdata_next = w_wdata_in[w_pick];
            w_mem_read_next  = ~w_we_in[w_pick];
            w_mem_write_next = w_we_in[w_pick];
          end else begin
            // Illegal address: answer immediately, memory is never strobed.
            w_state_next         = ERR;
            w_ack_next[w_pick]   = 1'b1;
            w_err_next[w_pick]   = 1'b1;
          end
        end
      end
      ACCESS: begin
        w_state_next      = RESP;
        w_ack_next[r_gnt] = 1'b1;
        if (!r_we) w_rdata_next[r_gnt] = mem_rdata;
      end
      RESP:    w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_ack        <= '0;
      r_err        <= '0;
      r_rdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_gnt        <= w_gnt_next;
      r_last_grant <= w_last_grant_next;
      r_we         <= w_we_next;
      r_ack        <= w_ack_next;
      r_err        <= w_err_next;
      r_rdata      <= w_rdata_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_read   <= w_mem_read_next;
      r_mem_write  <= w_mem_write_next;
    end
  end

  assign r0_ack    = r_ack[0];
  assign r1_ack    = r_ack[1];
  assign r0_err    = r_err[0];
  assign r1_err    = r_err[1];
  assign r0_rdata  = r_rdata[0];
  assign r1_rdata  = r_rdata[1];
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed timing checks plus randomized two-port traffic
// scored against a byte-level memory model; a fixed-priority instance shares the stimulus.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset, mem_clear;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic        fp_r0_ack, fp_r0_err, fp_r1_ack, fp_r1_err;
  logic [31:0] fp_r0_rdata, fp_r1_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic        fp_mem_read, fp_mem_write;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  txn_t        q0[$];
  txn_t        q1[$];
  logic [31:0] last_rd [2];

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_legal = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_LIMIT(256), .ROUND_ROBIN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_LIMIT(256), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(fp_r0_ack), .r0_err(fp_r0_err), .r0_rdata(fp_r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(fp_r1_ack), .r1_err(fp_r1_err), .r1_rdata(fp_r1_rdata),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_read(fp_mem_read),
    .mem_write(fp_mem_write), .mem_rdata(fp_mem_rdata)
  );

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 29 + 7);
  endfunction

  // Memory: combinational little-endian word read, written only by the main DUT.
  always_comb begin
    mem_rdata    = 32'h0;
    fp_mem_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      mem_rdata[8*k +: 8]    = mem[8'(mem_addr[7:0] + 8'(k))];
      fp_mem_rdata[8*k +: 8] = mem[8'(fp_mem_addr[7:0] + 8'(k))];
    end
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int k = 0; k < 256; k++) mem[k] <= pat(k);
    end else if (mem_write) begin
      for (int k = 0; k < 4; k++) mem[8'(mem_addr[7:0] + 8'(k))] <= mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(a[7:0] + 8'(k))];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
    else        begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
  endtask

  task automatic push(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (p == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    drive(p, 1'b1, we, addr, wdata);
    push(p, we, addr, wdata);
  endtask

  task automatic wait_ack(input int p);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? r0_ack : r1_ack;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL ack_timeout port%0d: got no ack, expected ack within 20 cycles", p);
    end
  endtask

  // Reference behaviour, applied in completion order: out-of-range -> err with rdata held;
  // legal write -> bytes stored, rdata held; legal read -> word from memory.
  task automatic score(input int p, input logic err, input logic [31:0] rdata);
    txn_t        t;
    logic        exp_err;
    logic [31:0] exp_rd;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_cmp++; n_bad++;
      $display("FAIL spurious_ack port%0d: got ack, expected none outstanding", p);
      return;
    end
    t = (p == 0) ? q0.pop_front() : q1.pop_front();
    exp_rd = last_rd[p];
    if (t.addr > 32'd252) begin
      exp_err = 1'b1;
    end else begin
      exp_err = 1'b0;
      n_legal++;
      if (t.we) begin
        for (int k = 0; k < 4; k++) ref_mem[8'(t.addr[7:0] + 8'(k))] = t.wdata[8*k +: 8];
      end else begin
        exp_rd = ref_word(t.addr);
      end
    end
    last_rd[p] = exp_rd;
    $display("txn port%0d we=%0b addr=0x%08h wdata=0x%08h -> err=%0b rdata=0x%08h",
             p, t.we, t.addr, t.wdata, err, rdata);
    chk($sformatf("err_port%0d", p), {31'h0, err}, {31'h0, exp_err});
    chk($sformatf("rdata_port%0d", p), rdata, exp_rd);
  endtask

  // Monitor: invariants every cycle, scoreboard on every ack.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      n_cmp++;
      if ((mem_read & mem_write) | (r0_ack & r1_ack) | (r0_err & ~r0_ack) | (r1_err & ~r1_ack) |
          (fp_mem_read & fp_mem_write) | (fp_r0_err & ~fp_r0_ack) | (fp_r1_err & ~fp_r1_ack)) begin
        n_bad++;
        $display("FAIL invariant: rd=%0b wr=%0b ack0=%0b ack1=%0b err0=%0b err1=%0b, expected exclusive strobes/acks and err only with ack",
                 mem_read, mem_write, r0_ack, r1_ack, r0_err, r1_err);
      end
      if (mem_read | mem_write) n_strobe++;
      if (r0_ack) score(0, r0_err, r0_rdata);
      if (r1_ack) score(1, r1_err, r1_rdata);
    end
  end

  task automatic rand_driver(input int p);
    logic        we;
    logic [31:0] addr;
    bit          keep = 0;
    for (int t = 0; t < 30; t++) begin
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        7:       addr = 32'($urandom_range(253, 255));
        8:       addr = 32'd252;
        9:       addr = $urandom | 32'h0000_0100;
        default: addr = 32'($urandom_range(0, 252));
      endcase
      issue(p, we, addr, $urandom);
      wait_ack(p);
      keep = 1'($urandom_range(0, 1));
      if (!keep) drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e0, e1;
    reset = 1'b1; mem_clear = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
    last_rd[0] = 0; last_rd[1] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_clear = 1'b0;
    @(negedge clk);
    chk("rst_r0_ack", {31'h0, r0_ack}, 0);
    chk("rst_r1_ack", {31'h0, r1_ack}, 0);
    chk("rst_errs", {30'h0, r0_err, r1_err}, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 0);

    // Port 0 write
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_mem_write", {31'h0, mem_write}, 1);
    chk("wr_mem_read", {31'h0, mem_read}, 0);
    chk("wr_mem_addr", mem_addr, 32'h10);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_no_early_ack", {31'h0, r0_ack}, 0);
    @(negedge clk);
    chk("wr_ack", {31'h0, r0_ack}, 1);
    chk("wr_err", {31'h0, r0_err}, 0);
    chk("wr_strobe_off", {31'h0, mem_write}, 0);
    drive(0, 0, 0, 0, 0);

    // Port 1 preloads 0x11223344 then reads it back
    @(negedge clk);
    issue(1, 1'b1, 32'h10, 32'h11223344);
    wait_ack(1);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    issue(1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rd_mem_read", {31'h0, mem_read}, 1);
    chk("rd_r0_quiet", {31'h0, r0_ack}, 0);
    @(negedge clk);
    chk("rd_r1_ack", {31'h0, r1_ack}, 1);
    chk("rd_r1_rdata", r1_rdata, 32'h11223344);
    chk("rd_r0_quiet2", {31'h0, r0_ack}, 0);
    drive(1, 0, 0, 0, 0);

    // Contention: both held; round robin alternates, fixed priority keeps port 0
    @(negedge clk);
    issue(0, 1'b0, 32'h40, 32'h0);
    issue(1, 1'b0, 32'h80, 32'h0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      e0 = (c == 2 || c == 8);
      e1 = (c == 5 || c == 11);
      chk($sformatf("rr_ack0_c%0d", c), {31'h0, r0_ack}, {31'h0, e0});
      chk($sformatf("rr_ack1_c%0d", c), {31'h0, r1_ack}, {31'h0, e1});
      chk($sformatf("fp_ack0_c%0d", c), {31'h0, fp_r0_ack}, {31'h0, (c == 2 || c == 5 || c == 8)});
      chk($sformatf("fp_ack1_c%0d", c), {31'h0, fp_r1_ack}, {31'h0, (c == 11)});
      if (c == 2) push(0, 1'b0, 32'h40, 32'h0);
      if (c == 5) push(1, 1'b0, 32'h80, 32'h0);
      if (c == 8) drive(0, 0, 0, 0, 0);
      if (c == 11) drive(1, 0, 0, 0, 0);
    end

    // Range boundaries on port 0
    @(negedge clk);
    issue(0, 1'b1, 32'hFC, 32'hCAFEF00D);
    @(negedge clk);
    chk("fc_mem_write", {31'h0, mem_write}, 1);
    @(negedge clk);
    chk("fc_ack", {31'h0, r0_ack}, 1);
    chk("fc_err", {31'h0, r0_err}, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    issue(0, 1'b0, 32'hFD, 32'h0);
    @(negedge clk);
    chk("fd_ack", {31'h0, r0_ack}, 1);
    chk("fd_err", {31'h0, r0_err}, 1);
    chk("fd_strobes", {30'h0, mem_read, mem_write}, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fd_ack_done", {31'h0, r0_ack}, 0);
    chk("fd_strobes2", {30'h0, mem_read, mem_write}, 0);
    issue(0, 1'b1, 32'h100000FC, 32'h12345678);
    @(negedge clk);
    chk("big_ack", {31'h0, r0_ack}, 1);
    chk("big_err", {31'h0, r0_err}, 1);
    chk("big_strobes", {30'h0, mem_read, mem_write}, 0);
    drive(0, 0, 0, 0, 0);

    // Back-to-back with changed address
    @(negedge clk);
    issue(0, 1'b0, 32'h20, 32'h0);
    wait_ack(0);
    issue(0, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    chk("b2b_gap", {31'h0, r0_ack}, 0);
    @(negedge clk);
    chk("b2b_mem_addr", mem_addr, 32'h24);
    chk("b2b_mem_read", {31'h0, mem_read}, 1);
    @(negedge clk);
    chk("b2b_ack2", {31'h0, r0_ack}, 1);
    drive(0, 0, 0, 0, 0);

    // Reset during the ACCESS cycle of a port 0 read
    @(negedge clk);
    issue(0, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk("rst_mid_access", {31'h0, mem_read}, 1);
    reset = 1'b1;
    q0.delete(); q1.delete();
    last_rd[0] = 0; last_rd[1] = 0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_ack", {31'h0, r0_ack}, 0);
    chk("rst_mid_strobes", {30'h0, mem_read, mem_write}, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_r1_rdata", r1_rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    issue(1, 1'b0, 32'h10, 32'h0);
    wait_ack(1);
    drive(1, 0, 0, 0, 0);

    // Randomized concurrent traffic on both ports
    @(negedge clk);
    n_strobe = 0; n_legal = 0;
    fork
      rand_driver(0);
      rand_driver(1);
    join
    repeat (4) @(negedge clk);
    chk("strobe_cycles_vs_legal", 32'(n_strobe), 32'(n_legal));
    chk("queues_drained", 32'(q0.size() + q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressed, word-access data memory (256 bytes, combinational read, level-driven write strobes).
- Port 0 is the core's load/store unit; port 1 is the debug/loader port used to preload or inspect data memory.
- Grants one requester at a time, range-checks the address, drives the memory control signals for exactly one cycle, then returns a registered response with a one-cycle ack.

Parameters:
- ADDR_LIMIT, 256: memory size in bytes; a word access is legal only if addr <= ADDR_LIMIT-4.
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  port 0 transaction request
- r0_we  in  1  port 0: 1 = write, 0 = read
- r0_addr  in  32  port 0 byte address
- r0_wdata  in  32  port 0 write data
- r0_ack  out  1  port 0 one-cycle completion pulse
- r0_err  out  1  port 0 range error, valid with r0_ack
- r0_rdata  out  32  port 0 read data, valid with r0_ack on reads
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same widths and meanings as the port 0 signals, for port 1
- mem_addr  out  32  to memory data_address
- mem_wdata  out  32  to memory write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  32  from memory read_data

Behaviour:
- All outputs are registered.
- Reset, synchronous: state=IDLE; all acks, errs, rdata, mem_addr, mem_wdata, mem_read and mem_write = 0; last_grant=1, so port 0 wins the first contention.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both reqs, ROUND_ROBIN=1: grant the port that is not last_grant. ROUND_ROBIN=0: grant port 0.
  - On grant: latch we, addr and wdata from the granted port, and update last_grant.
  - Legality check is on the full 32-bit addr: legal if addr <= ADDR_LIMIT-4. Legal -> ACCESS; otherwise -> ERR.
  - Unaligned legal addresses are allowed.
- ACCESS, one cycle:
  - mem_addr = latched addr.
  - mem_wdata = latched wdata.
  - mem_read = ~we, mem_write = we.
  - Next state RESP.
- RESP:
  - Deassert mem_read and mem_write; mem_addr and mem_wdata hold their last value.
  - Granted port: ack=1 and err=0.
  - Reads: rdata = mem_rdata captured on the ACCESS->RESP edge. Writes: rdata holds its previous value.
  - Next state IDLE.
- ERR:
  - Granted port: ack=1 and err=1; rdata unchanged.
  - mem_read and mem_write are never asserted for this transaction.
  - Next state IDLE.
- Latency:
  - req seen in IDLE at cycle N -> ack at N+2 for a legal access, or at N+1 for an error.
  - Peak throughput is one legal access per 3 cycles.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - If req is still high in the cycle after ack, that is a new request, arbitrated in that IDLE cycle. This gives back-to-back accesses with new fields.
  - req dropped before ack is a protocol violation; the arbiter completes the transaction using the latched fields and still pulses ack.
- Invariants:
  - mem_read and mem_write are never high together.
  - At most one of r0_ack and r1_ack is high in any cycle.
  - err is only ever high together with its own port's ack.
  - mem_read and mem_write are high for exactly one cycle per legal transaction.
- Byte order: data passes through unmodified in both directions; the arbiter does no byte-lane swapping.
- Reset mid-operation:
  - Reset in IDLE, ACCESS, RESP or ERR returns to IDLE at that edge; the in-flight transaction is abandoned and no ack is issued.
  - A write whose ACCESS cycle was already driven before reset has completed in memory.
  - last_grant returns to 1.

Test Plan:
- Port0 write, addr 0x10, data 0xDEADBEEF, req at cycle N -> at N+1: mem_write=1, mem_read=0, mem_addr=0x10, mem_wdata=0xDEADBEEF. At N+2: r0_ack=1, r0_err=0, mem_write=0.
- Port1 read, addr 0x10, memory model returns 0x11223344 -> at N+1: mem_read=1. At N+2: r1_ack=1 and r1_rdata=0x11223344; r0_ack stays 0 throughout.
- Both reqs held high after reset:
  - ROUND_ROBIN=1: grants alternate 0,1,0,1; acks at N+2, N+5, N+8, N+11.
  - ROUND_ROBIN=0: only port 0 is acked while r0_req stays high.
- Range checks on port 0:
  - addr 0xFC: legal, ack at N+2.
  - addr 0xFD: r0_ack=1 and r0_err=1 at N+1; mem_read and mem_write stay 0.
  - addr 0x100000FC: error, same response as 0xFD.
- Reset asserted in the ACCESS cycle of a port0 read -> next cycle: state IDLE, r0_ack=0, all outputs 0. A following port1 request is served normally.
- Port0 keeps req high after ack, changing addr 0x20 to 0x24 -> second access is accepted in the IDLE cycle right after ack: mem_addr=0x24 two cycles after the first ack, second ack three cycles after the first.
